sdram_rw_seq: RTL

Single-access SDRAM read/write command sequencer. It accepts one request at a time from the host-side arbiter and issues ACTIVE, READ/WRITE and PRECHARGE to the SDRAM pins with programmable tRCD and tRP. It honours CAS latency before flagging read data valid, and generates per-beat data strobes. It sits between the host request interface and the SDRAM I/O registers.

---
 rtl/sdram_defs.sv | 43 ++++
 rtl/sdram_delay_cntr.sv | 47 ++++
 rtl/sdram_rw_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_defs.sv
// ============================================================================
//  Package : sdram_defs
//  Shared command encodings, sequencer state type and helper function for the
//  SDRAM read/write sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_defs;

  // SDRAM commands as {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;

  // Address bit that selects auto-precharge on RD/WR and all-banks on PRE
  localparam int A10 = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACT   = 3'd1,
    ST_RCD   = 3'd2,
    ST_RDWR  = 3'd3,
    ST_CL    = 3'd4,
    ST_BURST = 3'd5,
    ST_PRE   = 3'd6,
    ST_RP    = 3'd7
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_delay_cntr.sv
// ============================================================================
//  Module  : sdram_delay_cntr
//  Loadable down-counter with a terminal-count flag for the current value and
//  a look-ahead flag telling whether the value after this edge will be zero.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_delay_cntr #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o,
  output logic         tc_next_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  // Counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o      = (cnt_q == '0);
  assign tc_next_o = (cnt_d == '0);

endmodule

`default_nettype wire

// File: rtl/sdram_rw_seq.sv
// ============================================================================
//  Module  : sdram_rw_seq
//  Single-access SDRAM command sequencer: ACT, RD/WR, PRE with programmable
//  tRCD/tRP, CAS-latency wait and per-beat read-valid / write-next strobes.
//  Config  : define SDRAM_RW_SEQ_AUTO_PRECHARGE_EN to use auto-precharge
//            (A10=1 on RD/WR, NOP in place of the explicit PRE).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_rw_seq
  import sdram_defs::*;
#(
  parameter int ROW_W     = 12,
  parameter int COL_W     = 8,
  parameter int BA_W      = 2,
  parameter int BURST_LEN = 4,
  parameter int TRCD      = 2,
  parameter int TRP       = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          req,
  input  logic                          req_wr,
  input  logic [BA_W+ROW_W+COL_W-1:0]   req_addr,
  input  logic [1:0]                    cas_lat,
  output logic                          ack,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    sd_cmd,
  output logic [BA_W-1:0]               sd_ba,
  output logic [ROW_W-1:0]              sd_addr,
  output logic                          rd_valid,
  output logic                          wr_next
);

  localparam int CNT_W = $clog2(max4(TRCD, TRP, 3, BURST_LEN)) + 1;

  localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'((TRCD >= 2) ? (TRCD - 2) : 0);
  localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(BURST_LEN - 1);
`ifdef SDRAM_RW_SEQ_AUTO_PRECHARGE_EN
  // One extra RP cycle stands in for the skipped PRE slot
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(TRP);
`else
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(TRP - 1);
`endif

  // Request field slices
  wire [BA_W-1:0]  req_ba  = req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  wire [ROW_W-1:0] req_row = req_addr[ROW_W+COL_W-1 -: ROW_W];
  wire [COL_W-1:0] req_col = req_addr[COL_W-1:0];

  state_e state_q, state_d;

  // Access context captured on ACT
  logic [BA_W-1:0]  ba_q;
  logic [COL_W-1:0] col_q;
  logic             wr_q;
  logic [1:0]       cl_q;

  // Registered pin values
  logic [2:0]       cmd_q,  cmd_d;
  logic [BA_W-1:0]  sba_q,  sba_d;
  logic [ROW_W-1:0] saddr_q, saddr_d;
  logic             ack_q,  ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdv_q,  rdv_d;
  logic             wrn_q,  wrn_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_tc;
  logic             cnt_tc_next;

  sdram_delay_cntr #(
    .W (CNT_W)
  ) u_delay_cntr (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tc_o       (cnt_tc),
    .tc_next_o  (cnt_tc_next)
  );

  // Next-state decision and interval-counter load on every state entry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req) state_d = ST_ACT;
      ST_ACT:   state_d = (TRCD > 1) ? ST_RCD : ST_RDWR;
      ST_RCD:   if (cnt_tc) state_d = ST_RDWR;
      ST_RDWR:  state_d = (wr_q || (cl_q == 2'd1)) ? ST_BURST : ST_CL;
      ST_CL:    if (cnt_tc) state_d = ST_BURST;
`ifdef SDRAM_RW_SEQ_AUTO_PRECHARGE_EN
      ST_BURST: if (cnt_tc) state_d = ST_RP;
`else
      ST_BURST: if (cnt_tc) state_d = ST_PRE;
`endif
      ST_PRE:   state_d = ST_RP;
      // A request held through done is taken straight away
      ST_RP:    if (cnt_tc) state_d = req ? ST_ACT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_RCD:   cnt_load_val = LD_RCD;
      ST_CL:    cnt_load_val = {{(CNT_W-2){1'b0}}, cl_q - 2'd2};
      ST_BURST: cnt_load_val = LD_BURST;
      ST_RP:    cnt_load_val = LD_RP;
      default:  cnt_load_val = '0;
    endcase
  end

  // Pin values for the coming cycle, decoded from the state being entered
  always_comb begin
    cmd_d   = CMD_NOP;
    sba_d   = '0;
    saddr_d = '0;
    ack_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = 1'b0;
    rdv_d   = 1'b0;
    wrn_d   = 1'b0;
    case (state_d)
      ST_ACT: begin
        cmd_d   = CMD_ACT;
        sba_d   = req_ba;
        saddr_d = req_row;
        ack_d   = 1'b1;
      end
      ST_RDWR: begin
        cmd_d                 = wr_q ? CMD_WR : CMD_RD;
        sba_d                 = ba_q;
        saddr_d[COL_W-1:0]    = col_q;
`ifdef SDRAM_RW_SEQ_AUTO_PRECHARGE_EN
        saddr_d[A10]          = 1'b1;
`else
        saddr_d[A10]          = 1'b0;
`endif
        wrn_d                 = wr_q;
      end
      ST_BURST: begin
        rdv_d = ~wr_q;
        // Last burst cycle of a write is the tWR gap
        wrn_d = wr_q & ~cnt_tc_next;
      end
      ST_PRE: begin
        cmd_d = CMD_PRE;
        sba_d = ba_q;
      end
      ST_RP: done_d = cnt_tc_next;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Capture the access context on the edge that enters ACT
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ba_q  <= '0;
      col_q <= '0;
      wr_q  <= 1'b0;
      cl_q  <= 2'd1;
    end else if (state_d == ST_ACT) begin
      ba_q  <= req_ba;
      col_q <= req_col;
      wr_q  <= req_wr;
      cl_q  <= (cas_lat == 2'd0) ? 2'd1 : cas_lat;
    end
  end

  // Output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cmd_q   <= CMD_NOP;
      sba_q   <= '0;
      saddr_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      wrn_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      sba_q   <= sba_d;
      saddr_q <= saddr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      wrn_q   <= wrn_d;
    end
  end

  assign sd_cmd   = cmd_q;
  assign sd_ba    = sba_q;
  assign sd_addr  = saddr_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rdv_q;
  assign wr_next  = wrn_q;

endmodule

`default_nettype wire
